// File: rtl/riscy_data_mem_responder.sv
// riscy_data_mem_responder
//   Memory-side model of the RI5CY data port (req/gnt/rvalid). Grants core
//   requests after GNT_DELAY cycles of held req, commits stores with byte
//   enables to a word-addressed RAM, and answers every granted request in
//   order exactly RVALID_LATENCY cycles after its handshake edge. Each
//   committed store is echoed for one cycle on the mon_* port.
// Ports
//   clk_i, rst_ni        clock, async active-low reset
//   data_req_o           core request
//   data_we_o            1 = store, 0 = load
//   data_be_o            byte enables
//   data_addr_o          byte address (word index taken from addr[AW+1:2])
//   data_wdata_o         store data
//   data_gnt_i           grant (combinational from FSM state + req)
//   data_rvalid_i        response valid
//   data_rdata_i         load data; 0 for store responses, held when idle
//   mon_valid_o          one-cycle pulse per committed store
//   mon_addr_o           committed word-aligned byte address
//   mon_wdata_o          committed word after byte merge
module riscy_data_mem_responder #(
    parameter int MEM_WORDS       = 1024,
    parameter int GNT_DELAY       = 0,
    parameter int RVALID_LATENCY  = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_o,
    output logic        data_gnt_i,
    output logic        data_rvalid_i,
    input  logic        data_we_o,
    input  logic [3:0]  data_be_o,
    input  logic [31:0] data_addr_o,
    input  logic [31:0] data_wdata_o,
    output logic [31:0] data_rdata_i,
    output logic        mon_valid_o,
    output logic [31:0] mon_addr_o,
    output logic [31:0] mon_wdata_o
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int STAGES = RVALID_LATENCY - 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int DW = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       outst_q;
    logic                slot_free;
    logic                gnt_raw;
    logic                hs;
    logic [AW-1:0]       widx;
    logic [31:0]         cur_word;
    logic [31:0]         merged;
    logic [31:0]         resp_data;
    logic [STAGES:0]     vld_pipe;
    logic [STAGES:0][31:0] dat_pipe;
    logic [31:0]         mem [MEM_WORDS];

    // Only addr[1:0] is dropped outright; bits above AW+1 alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, data_addr_o[1:0]};

    assign widx     = data_addr_o[AW+1:2];
    assign cur_word = mem[widx];

    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++)
            if (data_be_o[i]) merged[8*i +: 8] = data_wdata_o[8*i +: 8];
    end

    // A full window still accepts when the oldest response retires this cycle.
    assign slot_free = (outst_q < CW'(MAX_OUTSTANDING)) ||
                       ((outst_q == CW'(MAX_OUTSTANDING)) && data_rvalid_i);

    // Grant FSM: WAIT counts held-req cycles; cnt==GNT_DELAY grants.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_raw = 1'b0;
        if (GNT_DELAY == 0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            gnt_raw = data_req_o && slot_free;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (data_req_o && slot_free) begin
                        state_d = S_WAIT;
                        cnt_d   = DW'(1);
                    end
                end
                S_WAIT: begin
                    if (!data_req_o) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DW'(GNT_DELAY)) begin
                        if (slot_free) begin
                            gnt_raw = 1'b1;
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Gate with reset so gnt drops the instant reset asserts.
    assign data_gnt_i = gnt_raw && rst_ni;
    assign hs         = data_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q <= '0;
        end else begin
            case ({hs, data_rvalid_i})
                2'b10:   outst_q <= outst_q + CW'(1);
                2'b01:   if (outst_q != '0) outst_q <= outst_q - CW'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    // RAM is intentionally left out of reset.
    always_ff @(posedge clk_i) begin
        if (hs && data_we_o) mem[widx] <= merged;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mon_valid_o <= 1'b0;
            mon_addr_o  <= '0;
            mon_wdata_o <= '0;
        end else begin
            mon_valid_o <= hs && data_we_o;
            if (hs && data_we_o) begin
                mon_addr_o  <= {data_addr_o[31:2], 2'b00};
                mon_wdata_o <= merged;
            end
        end
    end

    // Response pipeline: stage 0 loads at the handshake edge, the last stage
    // drives the core. The last data stage only loads on a valid entry so
    // rdata holds between responses.
    assign resp_data = data_we_o ? 32'h0 : cur_word;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= hs;
            if (STAGES > 0 || hs) dat_pipe[0] <= resp_data;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (k < STAGES || vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign data_rvalid_i = vld_pipe[STAGES];
    assign data_rdata_i  = dat_pipe[STAGES];

endmodule
